// File: rtl/uart_rx_parity_unit.sv
// uart_rx_parity_unit: receive-side parity engine for the UART RX path.
// Assembles data bits LSB-first from the RX controller's sample strobes,
// checks the trailing parity bit, and keeps sticky/counted error status.
//
// Strobe protocol: no back-pressure exists on this path. frame_start and
// sample_en are single-cycle qualifiers that are consumed in the cycle they
// are high. frame_start has priority, so a sample_en in the same cycle is
// dropped as the start bit. frame_done is a one-cycle valid for rx_data and
// par_err, and there is no ready signal.
module uart_rx_parity_unit #(
    parameter int DATA_MAX = 9,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                sample_en,
    input  logic                sampled_bit,
    input  logic                par_en,
    input  logic [1:0]          par_mode,
    input  logic [3:0]          data_len,
    input  logic                err_clr,
    output logic [DATA_MAX-1:0] rx_data,
    output logic                frame_done,
    output logic                par_err,
    output logic                par_err_sticky,
    output logic [CNT_W-1:0]    par_err_cnt,
    output logic                busy,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [3:0]       MAX_LEN = 4'(DATA_MAX);
    localparam logic [3:0]       MIN_LEN = 4'd5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_next;
    logic [3:0] len_q;
    logic       par_en_q;
    logic [1:0] par_mode_q;
    logic [3:0] bit_cnt;
    logic       acc;

    logic [3:0] len_clamped;
    logic       capture;
    logic       last_data;
    logic       par_sample;
    logic       err_bit;
    logic       done_next;
    logic       err_next;

    assign fsm_state = state;

    // Clamp the requested length into the supported 5..DATA_MAX window.
    always_comb begin
        len_clamped = data_len;
        if (data_len < MIN_LEN) begin
            len_clamped = MIN_LEN;
        end else if (data_len > MAX_LEN) begin
            len_clamped = MAX_LEN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. frame_start restarts from any state.
    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = DATA;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                DATA:    if (last_data) state_next = par_en_q ? PARITY : IDLE;
                PARITY:  if (sample_en) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output/strobe decode for the datapath. Samples that arrive alongside frame_start are discarded.
    always_comb begin
        capture    = (state == DATA) && sample_en && !frame_start;
        last_data  = capture && (bit_cnt == (len_q - 4'd1));
        par_sample = (state == PARITY) && sample_en && !frame_start;
        case (par_mode_q)
            2'b00:   err_bit = acc ^ sampled_bit;
            2'b01:   err_bit = ~(acc ^ sampled_bit);
            2'b10:   err_bit = ~sampled_bit;
            default: err_bit = sampled_bit;
        endcase
        done_next = (last_data && !par_en_q) || par_sample;
        err_next  = par_sample && err_bit;
    end

    // Frame datapath: config latch, bit assembly, parity accumulator, result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= MIN_LEN;
            par_en_q   <= 1'b0;
            par_mode_q <= 2'b00;
            bit_cnt    <= 4'd0;
            acc        <= 1'b0;
            rx_data    <= '0;
            frame_done <= 1'b0;
            par_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy       <= (state_next != IDLE);
            frame_done <= done_next;
            par_err    <= err_next;
            if (frame_start) begin
                len_q      <= len_clamped;
                par_en_q   <= par_en;
                par_mode_q <= par_mode;
                bit_cnt    <= 4'd0;
                acc        <= 1'b0;
                rx_data    <= '0;
            end else if (capture) begin
                // rx_data was cleared at frame_start, so OR-ing places each bit once.
                rx_data <= rx_data | (DATA_MAX'(sampled_bit) << bit_cnt);
                acc     <= acc ^ sampled_bit;
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Status bookkeeping. It acts in the frame_done cycle, and an error in that cycle overrides err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_sticky <= 1'b0;
            par_err_cnt    <= '0;
        end else if (frame_done && par_err) begin
            par_err_sticky <= 1'b1;
            if (err_clr) begin
                par_err_cnt <= CNT_W'(1);
            end else if (par_err_cnt != CNT_MAX) begin
                par_err_cnt <= par_err_cnt + CNT_W'(1);
            end
        end else if (err_clr) begin
            par_err_sticky <= 1'b0;
            par_err_cnt    <= '0;
        end
    end

endmodule
